// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by an on-chip register-array memory.
// Independent write and read FSMs, one outstanding burst per direction, full-width beats only.
module axi4_slave_mem #(
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_ADDR_WIDTH = 30,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned B      = $clog2(STRB_W);
  localparam int unsigned DEPTH  = 2 ** MEM_ADDR_WIDTH;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // FIXED holds the word index; every other burst type increments and wraps at the top.
  function automatic logic [MEM_ADDR_WIDTH-1:0] next_idx(input logic [MEM_ADDR_WIDTH-1:0] idx,
                                                         input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + MEM_ADDR_WIDTH'(1);
  endfunction

  logic init_q;

  // ---------------- write path ----------------
  w_state_e                  w_state_q, w_state_d;
  logic [MEM_ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [7:0]                w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0]                w_burst_q, w_burst_d;
  logic [AXI_ID_WIDTH-1:0]   bid_d;
  logic [1:0]                bresp_d;
  logic                      awready_d, wready_d, bvalid_d;
  logic                      aw_hs, w_hs, b_hs, mem_we;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      init_q        <= 1'b0;
      w_state_q     <= W_IDLE;
      w_idx_q       <= '0;
      w_len_q       <= '0;
      w_beat_q      <= '0;
      w_burst_q     <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
    end else begin
      init_q        <= 1'b1;
      w_state_q     <= w_state_d;
      w_idx_q       <= w_idx_d;
      w_len_q       <= w_len_d;
      w_beat_q      <= w_beat_d;
      w_burst_q     <= w_burst_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bid     <= bid_d;
      s_axi_bresp   <= bresp_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_burst_d = w_burst_q;
    bid_d     = s_axi_bid;
    bresp_d   = s_axi_bresp;
    mem_we    = 1'b0;
    if (aw_hs) begin
      w_idx_d   = s_axi_awaddr[MEM_ADDR_WIDTH+B-1:B];
      w_len_d   = s_axi_awlen;
      w_burst_d = s_axi_awburst;
      w_beat_d  = '0;
      bid_d     = s_axi_awid;
    end
    if (w_hs) begin
      mem_we   = 1'b1;
      w_beat_d = w_beat_q + 8'd1;
      w_idx_d  = next_idx(w_idx_q, w_burst_q);
      // Early or late wlast still commits data but flags the burst
      if (s_axi_wlast) bresp_d = (w_beat_q == w_len_q) ? RESP_OKAY : RESP_SLVERR;
    end
    awready_d = init_q && (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e                  r_state_q, r_state_d;
  logic [MEM_ADDR_WIDTH-1:0] r_idx_q, r_idx_d, rd_idx;
  logic [7:0]                r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0]                r_burst_q, r_burst_d;
  logic [AXI_ID_WIDTH-1:0]   rid_d;
  logic                      arready_d, rvalid_d, rlast_d;
  logic                      ar_hs, r_hs, rd_load;

  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign r_hs        = s_axi_rvalid && s_axi_rready;
  assign s_axi_rresp = RESP_OKAY;

  // Only the word-index bits of the byte addresses select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q     <= R_IDLE;
      r_idx_q       <= '0;
      r_len_q       <= '0;
      r_beat_q      <= '0;
      r_burst_q     <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
    end else begin
      r_state_q     <= r_state_d;
      r_idx_q       <= r_idx_d;
      r_len_q       <= r_len_d;
      r_beat_q      <= r_beat_d;
      r_burst_q     <= r_burst_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rlast   <= rlast_d;
      s_axi_rid     <= rid_d;
      // Registered read sees the pre-write word on a same-cycle collision
      if (rd_load) s_axi_rdata <= mem[rd_idx];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (r_hs && s_axi_rlast) r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_burst_d = r_burst_q;
    rid_d     = s_axi_rid;
    rlast_d   = s_axi_rlast;
    rd_idx    = r_idx_q;
    rd_load   = 1'b0;
    if (ar_hs) begin
      r_idx_d   = s_axi_araddr[MEM_ADDR_WIDTH+B-1:B];
      r_len_d   = s_axi_arlen;
      r_burst_d = s_axi_arburst;
      r_beat_d  = '0;
      rid_d     = s_axi_arid;
      rd_idx    = s_axi_araddr[MEM_ADDR_WIDTH+B-1:B];
      rd_load   = 1'b1;
      rlast_d   = (s_axi_arlen == 8'd0);
    end else if (r_hs) begin
      if (s_axi_rlast) begin
        rlast_d = 1'b0;
      end else begin
        r_idx_d  = next_idx(r_idx_q, r_burst_q);
        rd_idx   = r_idx_d;
        rd_load  = 1'b1;
        r_beat_d = r_beat_q + 8'd1;
        rlast_d  = (r_beat_d == r_len_q);
      end
    end
    arready_d = init_q && (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: a byte-accurate memory model predicts B and R traffic.
module tb_axi4_slave_mem;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 30;
  localparam int unsigned IW = 4;
  localparam int unsigned MW = 10;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  always #5 clk = ~clk;

  axi4_slave_mem dut (
    .clk(clk), .aresetn(aresetn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
  } rexp_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] mdl [1 << MW];
  logic [DW-1:0] wbuf [256];
  logic [SW-1:0] sbuf [256];
  rexp_t         r_q [$];
  logic [IW+1:0] b_q [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [IW-1:0] id,
                             input int nbeats, input bit rnd);
    logic [MW-1:0] idx;
    logic [IW+1:0] be;
    int            beat, guard;
    bit            hs;
    b_q.push_back({id, (nbeats == int'(len) + 1) ? 2'b00 : 2'b10});
    idx = addr[MW+3:4];
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin tick(); guard++; end
    if (!awready) check("aw_timeout", 1'b0, 1'b1);
    tick();
    awvalid = 1'b0;
    check("wready_lat", wready, 1'b1);
    beat = 0; guard = 0;
    while (beat < nbeats && guard < 2000) begin
      wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata  = wbuf[beat];
      wstrb  = sbuf[beat];
      wlast  = (beat == nbeats - 1);
      hs     = wvalid && wready;
      tick();
      guard++;
      if (hs) begin
        for (int b = 0; b < int'(SW); b++)
          if (sbuf[beat][b]) mdl[idx][8*b +: 8] = wbuf[beat][8*b +: 8];
        if (burst != 2'b00) idx = idx + MW'(1);
        beat++;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (beat < nbeats) check("w_timeout", 1'b0, 1'b1);
    bready = 1'b1; guard = 0;
    while (!bvalid && guard < 50) begin tick(); guard++; end
    be = b_q.pop_front();
    if (bvalid) begin
      check("bresp", bresp, be[1:0]);
      check("bid", bid, be[IW+1:2]);
    end else begin
      check("b_timeout", 1'b0, 1'b1);
    end
    tick();
    bready = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [IW-1:0] id, input bit rnd);
    logic [MW-1:0] idx;
    rexp_t         e;
    logic [DW-1:0] held;
    logic          held_l, held_v, rr;
    int            got, guard;
    idx = addr[MW+3:4];
    for (int i = 0; i <= int'(len); i++) begin
      e.data = mdl[idx]; e.last = (i == int'(len)); e.id = id;
      r_q.push_back(e);
      if (burst != 2'b00) idx = idx + MW'(1);
    end
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin tick(); guard++; end
    if (!arready) check("ar_timeout", 1'b0, 1'b1);
    tick();
    arvalid = 1'b0;
    check("rvalid_lat", rvalid, 1'b1);
    got = 0; guard = 0; held_v = 1'b0; held = '0; held_l = 1'b0;
    while (got <= int'(len) && guard < 2000) begin
      rr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rready = rr;
      if (held_v) begin
        check("rdata_hold", rdata, held);
        check("rlast_hold", rlast, held_l);
      end
      held_v = 1'b0;
      if (rvalid && rr) begin
        e = r_q.pop_front();
        check("rdata", rdata, e.data);
        check("rlast", rlast, e.last);
        check("rid", rid, e.id);
        check("rresp", rresp, 2'b00);
        got++;
      end else if (rvalid) begin
        held_v = 1'b1; held = rdata; held_l = rlast;
      end
      tick();
      guard++;
    end
    rready = 1'b0;
    if (got <= int'(len)) begin
      check("r_timeout", 1'b0, 1'b1);
      r_q.delete();
    end
    check("rvalid_end", rvalid, 1'b0);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_bid_rid", {bid, rid, bresp, rresp}, '0);
    aresetn = 1'b1;
    tick();
    check("init_awready", awready, 1'b0);
    check("init_arready", arready, 1'b0);
    tick();
    check("post_awready", awready, 1'b1);
    check("post_arready", arready, 1'b1);

    // W beat offered before AW must be held off
    wvalid = 1'b1;
    tick(); tick();
    check("w_before_aw", wready, 1'b0);
    wvalid = 1'b0;

    // 32-beat incrementing pattern
    for (int i = 0; i < 32; i++) begin wbuf[i] = {16{8'(i)}}; sbuf[i] = '1; end
    write_burst(30'h0, 8'd31, 2'b01, 4'h5, 32, 1'b0);
    read_burst(30'h0, 8'd31, 2'b01, 4'h5, 1'b0);

    // Byte strobes on word 3
    wbuf[0] = '1; sbuf[0] = '1;
    write_burst(30'h30, 8'd0, 2'b01, 4'h1, 1, 1'b0);
    wbuf[0] = '0; sbuf[0] = 16'h00F0;
    write_burst(30'h30, 8'd0, 2'b01, 4'h2, 1, 1'b0);
    read_burst(30'h30, 8'd0, 2'b01, 4'h3, 1'b0);

    // Random back-pressure on both directions
    for (int i = 0; i < 32; i++) begin
      wbuf[i] = {$urandom, $urandom, $urandom, $urandom}; sbuf[i] = '1;
    end
    write_burst(30'h400, 8'd31, 2'b01, 4'h7, 32, 1'b1);
    read_burst(30'h400, 8'd31, 2'b01, 4'h9, 1'b1);

    // Wrap at top of memory, FIXED burst, WRAP treated as INCR
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {$urandom, $urandom, $urandom, $urandom}; sbuf[i] = '1;
    end
    write_burst(30'h3FF0, 8'd1, 2'b01, 4'hA, 2, 1'b0);
    read_burst(30'h3FF0, 8'd1, 2'b01, 4'hB, 1'b0);
    read_burst(30'h0, 8'd0, 2'b01, 4'hB, 1'b0);
    write_burst(30'h80, 8'd3, 2'b00, 4'hC, 4, 1'b0);
    read_burst(30'h80, 8'd0, 2'b01, 4'hC, 1'b0);
    write_burst(30'h100, 8'd3, 2'b10, 4'hD, 4, 1'b0);
    read_burst(30'h100, 8'd3, 2'b01, 4'hD, 1'b0);

    // Early and late wlast
    write_burst(30'h200, 8'd3, 2'b01, 4'hE, 2, 1'b0);
    read_burst(30'h200, 8'd1, 2'b01, 4'hE, 1'b0);
    write_burst(30'h220, 8'd1, 2'b01, 4'hF, 3, 1'b0);
    read_burst(30'h220, 8'd2, 2'b01, 4'hF, 1'b0);

    // Reset in the middle of a read burst
    arid = 4'h6; araddr = 30'h0; arlen = 8'd31; arburst = 2'b01; arvalid = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!arready && guard < 50) begin tick(); guard++; end
      if (!arready) check("ar_timeout_rst", 1'b0, 1'b1);
    end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    tick(); tick(); tick();
    check("mid_rvalid", rvalid, 1'b1);
    check("mid_rdata", rdata, mdl[3]);
    aresetn = 1'b0;
    rready = 1'b0;
    #1;
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_rdata", rdata, '0);
    tick();
    aresetn = 1'b1;
    tick();
    check("rel1_arready", arready, 1'b0);
    tick();
    check("rel2_arready", arready, 1'b1);
    read_burst(30'h0, 8'd31, 2'b01, 4'h6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

AXI4 slave memory responder: accepts AXI4 write and read bursts and services them from an on-chip register-array memory. It is the slave-side counterpart of the FIFO-to-AXI4 master adapter and replaces the DDR3 controller plus memory models in fast regression benches and small on-chip buffer designs. Write and read channels run independently, with one outstanding transaction per direction.

## Interface
- AXI_DATA_WIDTH, 128, data bus width in bits; must be a power of two, at least 8.
- AXI_ADDR_WIDTH, 30, byte address width.
- AXI_ID_WIDTH, 4, ID width.
- MEM_ADDR_WIDTH, 10, log2 of memory depth in data words (default 1024 words).

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_axi_awid, s_axi_awaddr, s_axi_awlen  in  ID/ADDR/8  write address, ID and burst length.
- s_axi_awburst  in  2  burst type.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata, s_axi_wstrb  in  DATA/DATA/8  write data and byte strobes.
- s_axi_wlast, s_axi_wvalid  in  1  last write beat; write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bid, s_axi_bresp  out  ID/2  write response ID and status.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid  in  ID/ADDR/8/2/1  read address channel.
- s_axi_arready  out  1  read address ready.
- s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid  out  ID/DATA/2/1/1  read data channel.
- s_axi_rready  in  1  read data ready.
- awsize and arsize are not ports: every beat is full bus width.
- lock, cache, prot, qos and region are not ports: callers leave them unconnected.

## Operation
- Let B = log2(AXI_DATA_WIDTH/8).
- Word index = addr[MEM_ADDR_WIDTH+B-1:B]. Upper address bits are ignored, so addresses alias modulo the memory depth. Low B bits are ignored.
- Burst type handling:
  - INCR (2'b01) advances the word index by 1 per beat, modulo 2^MEM_ADDR_WIDTH (wraps from the top word to word 0).
  - FIXED (2'b00) holds the index.
  - WRAP (2'b10) and reserved (2'b11) are treated as INCR.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch id, index, len and burst; clear the beat counter; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes of wdata whose wstrb bit is set, increments the beat counter and advances the index. The burst ends on the beat carrying wlast; then go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. bresp=2'b00, or 2'b10 (SLVERR) if wlast arrived on a beat other than beat number awlen. Data is committed either way. On bready go to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch id, index, len and burst; go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rresp=2'b00, rlast=1 on beat arlen. On each R handshake, advance the index and load the next word.
  - After the handshake on the rlast beat, go to R_IDLE.
- A W beat arriving before the AW handshake is held: wready stays 0.
- Same-word write and read in one cycle: the read returns the pre-write data.
- Memory contents are not reset.

## Timing
- All outputs are registered.
- During reset and in the first clk after aresetn rises:
  - awready, wready, bvalid, arready, rvalid, rlast = 0.
  - bresp, rresp = 0; bid, rid, rdata = 0.
- awready and arready assert in the second cycle after reset release.
- AW handshake in cycle T: wready=1 from T+1.
- Last W handshake in T: bvalid=1 at T+1. bready in T+k: awready=1 at T+k+1.
- AR handshake in T: first rvalid and rdata at T+1. Sustained rate is 1 beat/cycle while rready=1.
- rready=0: rdata, rlast and rid hold stable.
- wvalid=0 in W_DATA: no write and no counter change.
- Reset mid-burst: FSMs return to idle immediately and outputs take their reset values. Memory words already written keep their data.
- Beat counter is 8 bits, giving a maximum burst of 256 beats.

## Test plan
- Write awaddr=0, awlen=31, data beat i = i replicated, wstrb all ones, then read araddr=0, arlen=31 -> rdata beat i = i, rlast only on beat 31, bresp=rresp=0, bid/rid echo awid/arid=4'h5.
- Write word 3 all 0xFF, then rewrite it with wdata=0 and wstrb=16'h00F0 -> read of word 3 returns bytes 4..7 = 0x00, all other bytes 0xFF.
- Random wvalid/rready deassertion on a 32-beat burst -> data identical to the back-to-back case; rdata held stable while rready=0.
- awaddr=0x3FF0, awlen=1 -> beats land at words 1023 and 0. FIXED burst of 4 beats to word 8 -> word 8 holds beat 3 data.
- awlen=3 with wlast on beat 1 -> burst ends after 2 beats, bresp=2'b10. awlen=1 with no wlast by beat 1 -> wready stays high until wlast, then bresp=2'b10.
- Assert aresetn=0 for 1 cycle mid read burst -> rvalid=0 immediately, arready=1 two cycles after release, and a new burst completes correctly.
